// File: rtl/uart_byte_tx_if.sv
// Byte-output port between the CPU core and the UART transmitter.
//   master (CPU side): drives out_byte/out_byte_en, observes status and tx.
//   slave  (UART side): consumes the write strobe, drives tx, busy, full,
//                       level (occupancy, $clog2(FIFO_DEPTH)+1 bits), overflow.
interface uart_byte_tx_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    out_byte;
  logic          out_byte_en;
  logic          tx;
  logic          busy;
  logic          full;
  logic [LW-1:0] level;
  logic          overflow;

  modport master (output out_byte, out_byte_en,
                  input  tx, busy, full, level, overflow);
  modport slave  (input  out_byte, out_byte_en,
                  output tx, busy, full, level, overflow);
endinterface

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: buffers CPU byte strobes in a FIFO and serialises them as
// 8N1 UART frames (start 0, 8 data bits LSB first, stop 1), CLK_DIV clocks
// per bit. Back-to-back frames are continuous: the next start bit follows
// the last stop cycle directly.
// Ports:
//   clk    - system clock, rising edge
//   resetn - synchronous active-low reset
//   bus    - uart_byte_tx_if.slave: out_byte/out_byte_en in; tx, busy,
//            full, level, overflow (sticky dropped-write flag) out
module uart_byte_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           resetn,
  uart_byte_tx_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] count_q, count_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          busy_q, ovf_q;
  logic          pop, push, fifo_ne, full_w, tmr_last;

  assign fifo_ne  = (count_q != '0);
  assign full_w   = (count_q == LW'(FIFO_DEPTH));
  assign tmr_last = (tmr_q == TW'(CLK_DIV - 1));
  // A pop on the same edge frees the slot, so a write while full still lands.
  assign push     = bus.out_byte_en && (!full_w || pop);
  assign count_d  = count_q + LW'(push) - LW'(pop);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_last ? '0 : tmr_q + TW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        tx_d  = 1'b1;
        if (fifo_ne) begin
          pop     = 1'b1;
          sh_d    = mem[rptr_q];
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: if (tmr_last) begin
        tx_d    = sh_q[0];
        state_d = DATA;
      end
      DATA: if (tmr_last) begin
        // Index wraps 7->0 here, i.e. only at the end of the data field.
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          sh_d = {1'b0, sh_q[7:1]};
          tx_d = sh_q[1];
        end
      end
      STOP: if (tmr_last) begin
        if (fifo_ne) begin
          // Chain straight into the next start bit, no idle gap.
          pop     = 1'b1;
          sh_d    = mem[rptr_q];
          tx_d    = 1'b0;
          state_d = START;
        end else begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE) || (count_d != '0);
      ovf_q   <= ovf_q || (bus.out_byte_en && !push);
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
    end
  end

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (resetn && push) mem[wptr_q] <= bus.out_byte;
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.full     = full_w;
  assign bus.level    = count_q;
  assign bus.overflow = ovf_q;
endmodule
